mmio_hub: RTL and testbench

MMIO_HUB -- requirements
Module: mmio_hub

---
 rtl/mmio_hub.sv | 176 +++++++++++++++++
 tb/tb_mmio_hub.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_hub.sv
// mmio_hub: memory-mapped hub for switches, LEDs, 7-seg, debounced buttons, timer.
// Ports: clk, reset (async low); Address/WriteData/WriteEn/ReadEn bus;
//   Switch, Button in; LedOut, SegOut, ReadData, ReadValid out.
module mmio_hub #(
  parameter int NUM_SW     = 2,
  parameter int NUM_LED    = 2,
  parameter int NUM_BTN    = 5,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Address,
  input  logic [31:0]          WriteData,
  input  logic                 WriteEn,
  input  logic                 ReadEn,
  input  logic [8*NUM_SW-1:0]  Switch,
  input  logic [NUM_BTN-1:0]   Button,
  output logic [8*NUM_LED-1:0] LedOut,
  output logic [31:0]          SegOut,
  output logic [31:0]          ReadData,
  output logic                 ReadValid
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  // Assert asynchronously, release on a common clk edge.
  logic rst_q1, rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_q1 <= 1'b0;
      rst_n  <= 1'b0;
    end else begin
      rst_q1 <= 1'b1;
      rst_n  <= rst_q1;
    end
  end

  logic       hit;
  logic [5:0] widx;
  logic       sel_seg, sel_btn, sel_flg, sel_tmr;
  logic       unused_ok;

  assign hit       = Address[31:8] == 24'hFF_FFFF;
  assign widx      = Address[7:2];
  assign sel_seg   = hit && (widx == 6'h10);
  assign sel_btn   = hit && (widx == 6'h11);
  assign sel_flg   = hit && (widx == 6'h12);
  assign sel_tmr   = hit && (widx == 6'h13);
  assign unused_ok = ^Address[1:0];

  logic [8*NUM_SW-1:0] sw_s1, sw_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= Switch;
      sw_s2 <= sw_s1;
    end
  end

  logic [NUM_BTN-1:0] bt_s1, bt_s2, stab, flg;
  logic [NUM_BTN-1:0] accept, rise, clr;
  logic [CW-1:0]      cnt [NUM_BTN];

  always_comb begin
    accept = '0;
    rise   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      accept[i] = (bt_s2[i] != stab[i]) && (cnt[i] == CMAX);
      rise[i]   = accept[i] & bt_s2[i];
    end
  end

  assign clr = (WriteEn && sel_flg) ? WriteData[NUM_BTN-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bt_s1 <= '0;
      bt_s2 <= '0;
      stab  <= '0;
      flg   <= '0;
      for (int i = 0; i < NUM_BTN; i++)
        cnt[i] <= '0;
    end else begin
      bt_s1 <= Button;
      bt_s2 <= bt_s1;
      // set beats a coincident clear
      flg   <= (flg & ~clr) | rise;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (bt_s2[i] == stab[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stab[i] <= bt_s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  logic [31:0] tmr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LedOut <= '0;
      SegOut <= '0;
      tmr    <= '0;
    end else begin
      for (int i = 0; i < NUM_LED; i++)
        if (WriteEn && hit && (widx == 6'(8 + i)))
          LedOut[8*i +: 8] <= WriteData[7:0];
      if (WriteEn && sel_seg)
        SegOut <= WriteData;
      if (WriteEn && sel_tmr)
        tmr <= WriteData;
      else
        tmr <= tmr + 32'd1;
    end
  end

  logic [7:0]  sw_rd, led_rd;
  logic        sel_sw, sel_led;
  logic [31:0] rmux;

  always_comb begin
    sw_rd  = '0;
    sel_sw = 1'b0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (hit && (widx == 6'(i))) begin
        sel_sw = 1'b1;
        sw_rd  = sw_s2[8*i +: 8];
      end
    end
  end

  always_comb begin
    led_rd  = '0;
    sel_led = 1'b0;
    for (int i = 0; i < NUM_LED; i++) begin
      if (hit && (widx == 6'(8 + i))) begin
        sel_led = 1'b1;
        led_rd  = LedOut[8*i +: 8];
      end
    end
  end

  always_comb begin
    rmux = '0;
    unique case (1'b1)
      sel_sw:  rmux = {24'b0, sw_rd};
      sel_led: rmux = {24'b0, led_rd};
      sel_seg: rmux = SegOut;
      sel_btn: rmux = {{(32-NUM_BTN){1'b0}}, stab};
      sel_flg: rmux = {{(32-NUM_BTN){1'b0}}, flg};
      sel_tmr: rmux = tmr;
      default: rmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadData  <= '0;
      ReadValid <= 1'b0;
    end else begin
      ReadValid <= ReadEn;
      if (ReadEn)
        ReadData <= rmux;
    end
  end

endmodule

// File: tb/tb_mmio_hub.sv
// tb_mmio_hub: directed self-checking bench for mmio_hub.
// Small debounce window so button timing is checked cycle-exactly.
module tb_mmio_hub;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        WriteEn;
  logic        ReadEn;
  logic [15:0] Switch;
  logic [4:0]  Button;
  logic [15:0] LedOut;
  logic [31:0] SegOut;
  logic [31:0] ReadData;
  logic        ReadValid;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] A_SW0 = 32'hFFFF_FF00;
  localparam logic [31:0] A_SW1 = 32'hFFFF_FF04;
  localparam logic [31:0] A_SW2 = 32'hFFFF_FF08;
  localparam logic [31:0] A_LD0 = 32'hFFFF_FF20;
  localparam logic [31:0] A_LD1 = 32'hFFFF_FF24;
  localparam logic [31:0] A_LD3 = 32'hFFFF_FF2C;
  localparam logic [31:0] A_SEG = 32'hFFFF_FF40;
  localparam logic [31:0] A_BTN = 32'hFFFF_FF44;
  localparam logic [31:0] A_FLG = 32'hFFFF_FF48;
  localparam logic [31:0] A_TMR = 32'hFFFF_FF4C;
  localparam logic [31:0] A_BAD = 32'hFFFF_FF50;

  mmio_hub #(
    .NUM_SW(2),
    .NUM_LED(2),
    .NUM_BTN(5),
    .DEB_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Address(Address),
    .WriteData(WriteData),
    .WriteEn(WriteEn),
    .ReadEn(ReadEn),
    .Switch(Switch),
    .Button(Button),
    .LedOut(LedOut),
    .SegOut(SegOut),
    .ReadData(ReadData),
    .ReadValid(ReadValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    WriteData = d;
    WriteEn   = 1'b1;
    step();
    WriteEn   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    Address = a;
    ReadEn  = 1'b1;
    step();
    ReadEn  = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    Address   = '0;
    WriteData = '0;
    WriteEn   = 1'b0;
    ReadEn    = 1'b0;
    Switch    = '0;
    Button    = '0;

    repeat (3) step();
    chk("rst_led", 32'(LedOut), 32'h0);
    chk("rst_seg", SegOut, 32'h0);
    chk("rst_rdata", ReadData, 32'h0);
    chk("rst_rvalid", 32'(ReadValid), 32'h0);
    reset = 1'b1;
    repeat (4) step();

    // LED write and non-write
    wr(A_LD1, 32'h0000_00A5);
    chk("led1_wr", 32'(LedOut), 32'h0000_A500);
    Address   = A_LD1;
    WriteData = 32'h0000_00FF;
    step();
    chk("led1_nowr", 32'(LedOut), 32'h0000_A500);

    // switch read through synchroniser
    Switch = 16'h3C81;
    repeat (3) step();
    rd(A_SW1);
    chk("sw1_rd", ReadData, 32'h0000_003C);
    chk("sw1_valid", 32'(ReadValid), 32'h1);
    step();
    chk("sw1_valid_drop", 32'(ReadValid), 32'h0);
    chk("sw1_hold", ReadData, 32'h0000_003C);
    rd(A_SW0);
    chk("sw0_rd", ReadData, 32'h0000_0081);
    rd(A_SW2);
    chk("sw2_oob", ReadData, 32'h0);

    // low address bits ignored
    rd(A_LD1 | 32'h3);
    chk("led1_rd_lowbits", ReadData, 32'h0000_00A5);

    // simultaneous read/write returns pre-write value
    Address   = A_LD0;
    WriteData = 32'h0000_0055;
    WriteEn   = 1'b1;
    ReadEn    = 1'b1;
    step();
    WriteEn   = 1'b0;
    ReadEn    = 1'b0;
    chk("rw_same_old", ReadData, 32'h0);
    chk("rw_same_led", 32'(LedOut), 32'h0000_A555);
    rd(A_LD0);
    chk("led0_rd", ReadData, 32'h0000_0055);

    // read-only and unmapped writes ignored
    wr(A_SW0, 32'h0000_00FF);
    rd(A_SW0);
    chk("ro_write", ReadData, 32'h0000_0081);
    wr(A_LD3, 32'h0000_0077);
    chk("oob_led_write", 32'(LedOut), 32'h0000_A555);

    // seven-segment register
    wr(A_SEG, 32'h1234_5678);
    chk("seg_out", SegOut, 32'h1234_5678);
    rd(A_SEG | 32'h1);
    chk("seg_rd", ReadData, 32'h1234_5678);

    // timer load and wrap
    wr(A_TMR, 32'hFFFF_FFFE);
    step();
    rd(A_TMR);
    chk("tmr_ffff", ReadData, 32'hFFFF_FFFF);
    rd(A_TMR);
    chk("tmr_wrap0", ReadData, 32'h0);
    rd(A_TMR);
    chk("tmr_wrap1", ReadData, 32'h1);

    // bouncing Button[2]: no flag while bouncing
    Address = A_FLG;
    ReadEn  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      Button = (i % 2 == 0) ? 5'b00100 : 5'b00000;
      step();
      chk("bounce_flag", ReadData, 32'h0);
    end
    Button = 5'b00100;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("settle_flag", ReadData, 32'h0);
    end
    step();
    chk("edge_flag2", ReadData, 32'h0000_0004);
    ReadEn = 1'b0;
    rd(A_BTN);
    chk("btn_level2", ReadData, 32'h0000_0004);
    wr(A_FLG, 32'h0000_0004);
    rd(A_FLG);
    chk("flag2_clr", ReadData, 32'h0);

    // rising edge on Button[0] coincident with W1C: set wins
    Button = 5'b00101;
    repeat (5) step();
    wr(A_FLG, 32'h0000_0001);
    rd(A_FLG);
    chk("set_wins", ReadData, 32'h0000_0001);
    rd(A_BTN);
    chk("btn_level05", ReadData, 32'h0000_0005);

    // asynchronous reset pulse mid-read
    rd(A_FLG);
    chk("pre_rst_flag", ReadData, 32'h0000_0001);
    Address = A_FLG;
    ReadEn  = 1'b1;
    #2 reset = 1'b0;
    #2;
    chk("async_led", 32'(LedOut), 32'h0);
    chk("async_seg", SegOut, 32'h0);
    chk("async_rdata", ReadData, 32'h0);
    chk("async_rvalid", 32'(ReadValid), 32'h0);
    #1 reset = 1'b1;
    ReadEn = 1'b0;
    repeat (4) step();
    chk("post_rst_rvalid", 32'(ReadValid), 32'h0);
    chk("post_rst_led", 32'(LedOut), 32'h0);
    rd(A_FLG);
    chk("post_rst_flag", ReadData, 32'h0);
    rd(A_BAD);
    chk("unmapped_rd", ReadData, 32'h0);
    chk("unmapped_valid", 32'(ReadValid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
